// File: rtl/char_pkg.sv
// char_pkg: shared types and spawn constants for the character movement stage.
package char_pkg;
    localparam int HOR_PIXELS = vga_pkg::HOR_PIXELS;
    localparam int VER_PIXELS = vga_pkg::VER_PIXELS;
    localparam int DEFAULT_GROUND_Y = 550;
    localparam logic [11:0] SPAWN_X = 12'(HOR_PIXELS / 5);
    typedef enum logic [1:0] {GROUND, JUMP_UP, FALL} move_state_t;
endpackage

// File: rtl/vga_pkg.sv
// vga_pkg: display geometry shared by the video pipeline.
package vga_pkg;
    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;
endpackage

// File: rtl/char_edge_det.sv
// char_edge_det: two-flop synchroniser followed by a rising-edge detector.
module char_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise
);
    logic [2:0] r_sync;
    always_ff @(posedge clk) begin
        if (!rst) r_sync <= 3'b000;
        else      r_sync <= {r_sync[1:0], i_d};
    end
    assign o_rise = r_sync[1] & ~r_sync[2];
endmodule

// File: rtl/char_move.sv
// char_move: per-frame player movement and jump controller.
// Build with DOUBLE_JUMP_EN defined to allow one extra jump while airborne.
module char_move
    import char_pkg::*;
#(
    parameter int GROUND_Y  = DEFAULT_GROUND_Y,
    parameter int MOVE_STEP = 4,
    parameter int JUMP_V    = 12,
    parameter int GRAVITY   = 1,
    parameter int MAX_FALL  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    input  logic [1:0]  game_active,
    input  logic [3:0]  current_health,
    input  logic [11:0] char_hgt,
    input  logic [11:0] char_lng,
    output logic [11:0] pos_x,
    output logic [11:0] pos_y,
    output logic        flip_h,
    output logic        airborne
);
    localparam logic signed [12:0] STEP = 13'(MOVE_STEP);
    localparam logic signed [12:0] JV13 = 13'(JUMP_V);
    localparam logic signed [7:0]  JV   = 8'(JUMP_V);
    localparam logic signed [7:0]  GR   = 8'(GRAVITY);
    localparam logic signed [7:0]  MF   = 8'(MAX_FALL);

    move_state_t       r_state, w_state;
    logic signed [7:0] r_vy, w_vy, w_vy_g, w_vy_f;
    logic [11:0]       r_pos_x, r_pos_y;
    logic              r_flip, r_air, r_jump_req, r_dj, w_dj, w_rise, w_air_jump, w_left, w_right;
    logic signed [12:0] w_y, w_gt, w_hgt, w_lng, w_xmax, w_xs, w_nx, w_ny, w_y_up, w_y_fall;

    char_edge_det u_jump_edge (.clk(clk), .rst(rst), .i_d(btn_jump), .o_rise(w_rise));

    assign w_left  = btn_left & ~btn_right;
    assign w_right = btn_right & ~btn_left;
`ifdef DOUBLE_JUMP_EN
    assign w_air_jump = r_jump_req & ~r_dj;
`else
    assign w_air_jump = 1'b0;
`endif

    always_comb begin
        w_hgt    = $signed({1'b0, char_hgt});
        w_lng    = $signed({1'b0, char_lng});
        w_gt     = 13'(GROUND_Y) - w_hgt;
        w_xmax   = 13'(HOR_PIXELS) - w_lng;
        w_xs     = $signed({1'b0, r_pos_x}) + (w_left ? -STEP : w_right ? STEP : 13'sd0);
        w_nx     = w_xs < w_lng ? w_lng : w_xs > w_xmax ? w_xmax : w_xs;
        w_y      = $signed({1'b0, r_pos_y});
        w_vy_g   = r_vy + GR;
        w_vy_f   = w_vy_g > MF ? MF : w_vy_g;
        w_y_up   = w_y + $signed({{5{w_vy_g[7]}}, w_vy_g});
        w_y_fall = w_y + $signed({{5{w_vy_f[7]}}, w_vy_f});
        w_state  = r_state;
        w_vy     = r_vy;
        w_ny     = w_y;
        w_dj     = r_dj;
        if (r_state == GROUND) begin
            if (r_jump_req) begin
                w_state = JUMP_UP;
                w_vy    = -JV;
                w_ny    = w_y - JV13;
            end else if (w_y < w_gt) begin
                w_state = FALL;
                w_vy    = 8'sd0;
            end
        end else if (w_air_jump) begin
            w_state = JUMP_UP;
            w_vy    = -JV;
            w_dj    = 1'b1;
        end else if (r_state == JUMP_UP) begin
            if (w_y_up - w_hgt < 13'sd0) begin
                w_state = FALL;
                w_vy    = 8'sd0;
                w_ny    = w_hgt;
            end else begin
                w_state = w_vy_g >= 8'sd0 ? FALL : JUMP_UP;
                w_vy    = w_vy_g;
                w_ny    = w_y_up;
            end
        end else if (w_y_fall >= w_gt) begin
            w_state = GROUND;
            w_vy    = 8'sd0;
            w_ny    = w_gt;
            w_dj    = 1'b0;
        end else begin
            w_vy = w_vy_f;
            w_ny = w_y_fall;
        end
    end

    // Menu mode reloads spawn exactly like reset; paused or dead holds everything.
    always_ff @(posedge clk) begin
        if (!rst || (frame_tick && game_active == 2'd0)) begin
            r_pos_x    <= SPAWN_X;
            r_pos_y    <= 12'(GROUND_Y) - char_hgt;
            r_flip     <= 1'b0;
            r_air      <= 1'b0;
            r_vy       <= 8'sd0;
            r_state    <= GROUND;
            r_jump_req <= 1'b0;
            r_dj       <= 1'b0;
        end else begin
            r_jump_req <= w_rise | (r_jump_req & ~frame_tick);
            if (frame_tick && game_active == 2'd1 && current_health != 4'd0) begin
                r_pos_x <= w_nx[11:0];
                r_pos_y <= w_ny[11:0];
                r_flip  <= w_left ? 1'b1 : w_right ? 1'b0 : r_flip;
                r_air   <= w_state != GROUND;
                r_vy    <= w_vy;
                r_state <= w_state;
                r_dj    <= w_dj;
            end
        end
    end

    assign pos_x    = r_pos_x;
    assign pos_y    = r_pos_y;
    assign flip_h   = r_flip;
    assign airborne = r_air;
endmodule
